ram_wr_queue: RTL and testbench
===============================

Name: ram_wr_queue

Overview:
- Write-side front end for the 2R1W RAM. Buffers write requests from a producer in a small circular queue behind a valid/ready handshake.
- Drains one entry per cycle into the RAM write port (we/addrw/dinw) whenever the port is not stalled.
- Provides store-to-load forwarding on the two read addresses, so readers see data still pending in the queue.

Parameters:
DEPTH, 4, queue entries; power of two, >= 2
AW, 11, address width; matches the RAM address ports
DW, 32, data width; matches the RAM data ports

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous reset, active-high
in_valid  input  1  producer write request valid
in_ready  output  1  queue can accept; = (count != DEPTH)
in_addr  input  AW  write address
in_data  input  DW  write data
ram_stall  input  1  RAM write port unavailable this cycle
ram_we  output  1  write enable to RAM
ram_addrw  output  AW  write address to RAM (head entry)
ram_dinw  output  DW  write data to RAM (head entry)
rd_addr1  input  AW  read port 1 address (same value driven to the RAM)
rd_addr2  input  AW  read port 2 address
fwd_hit1  output  1  rd_addr1 matches a pending entry
fwd_data1  output  DW  data of youngest matching entry, else 0
fwd_hit2  output  1  as fwd_hit1, for port 2
fwd_data2  output  DW  as fwd_data1, for port 2
count  output  $clog2(DEPTH)+1  occupied entries
empty  output  1  count == 0

Behaviour:
- State: entry arrays addr/data/valid[DEPTH], wr_ptr, rd_ptr, count register.
- Reset (async, rst=1): pointers 0, count 0, all valid 0.
  - Resulting outputs: empty=1, in_ready=1, ram_we=0, fwd_hit*=0, fwd_data*=0.
  - ram_addrw/ram_dinw show entry[0] contents; don't-care while ram_we=0.
  - Reset mid-operation discards all pending writes. No RAM write occurs in the reset cycle.
- Push:
  - push = in_valid & in_ready.
  - Writes entry[wr_ptr], sets its valid bit, wr_ptr+1 mod DEPTH.
  - in_ready depends only on registered count; no combinational path from ram_stall or pop.
- Pop:
  - ram_we = !empty & !ram_stall, combinational.
  - ram_addrw/ram_dinw = entry[rd_ptr] directly.
  - Pop occurs when ram_we=1: clears valid[rd_ptr], rd_ptr+1 mod DEPTH.
- Count:
  - push only: +1. Pop only: -1. Both: unchanged.
  - Push into a full queue is impossible because in_ready=0. A pop in that same cycle does not raise in_ready until the next cycle.
- Latency: a write accepted at edge N is presented on ram_we at cycle N+1 at the earliest (empty queue, no stall).
- Ordering: strict FIFO; RAM sees writes in acceptance order. Stall holds the head entry and ram_addrw/ram_dinw stable.
- Forwarding (combinational, per port):
  - Compare rd_addrK against every valid entry. hit = any match.
  - data = youngest match, i.e. closest to wr_ptr-1 walking backwards; 0 if no match.
  - The entry being popped this cycle still counts, because the RAM commits it at the edge.
  - The in_* request of the current cycle is not searched.
- Pointer wrap: both pointers wrap DEPTH-1 -> 0; full/empty is resolved by count, not pointer equality.

Optional Feature:
- Macro: WRQ_COALESCE_EN
- Defined:
  - If a push finds a valid entry with equal address, in_data overwrites that entry's data in place. No new entry is allocated; wr_ptr and count are unchanged by the push.
  - Exception: if the matching entry is the head being popped this cycle, a normal enqueue is performed instead.
  - The youngest match is chosen if several exist.
  - in_ready becomes 1 even when full, provided in_addr matches a non-popping valid entry.
- Undefined: every push allocates a new entry. Duplicate addresses may coexist; forwarding returns the youngest.

Test Plan:
- Reset then single write (A=0x010, D=0xDEAD_BEEF), ram_stall=0 -> ram_we=1 next cycle with addrw=0x010, dinw=0xDEADBEEF; empty=1 after it.
- ram_stall=1, push 4 writes (0x001..0x004, D=1..4) -> count=4, in_ready=0, ram_we=0; release stall -> 4 consecutive ram_we cycles, addresses 1,2,3,4 in order.
- Queue full with stall; hold in_valid=1; release stall -> pop and push-acceptance separated by one cycle; count goes 4->3->3; no entry lost.
- Pending writes 0x005<-0x11 then 0x005<-0x22 (stall held); rd_addr1=0x005, rd_addr2=0x006 -> fwd_hit1=1, fwd_data1=0x22, fwd_hit2=0, fwd_data2=0.
- Assert rst asynchronously with 3 pending entries -> immediately count=0, ram_we=0, fwd_hit*=0; no writes appear after rst deasserts.
- WRQ_COALESCE_EN: stall held, push 0x007<-0xAA then 0x007<-0xBB -> count=1; release -> one RAM write, 0x007<-0xBB.

Source files
------------

// File: rtl/ram_wr_queue_if.sv
// rtl/ram_wr_queue_if.sv - producer, RAM write port and forwarding signals of ram_wr_queue
interface ram_wr_queue_if #(
    parameter int DEPTH = 4,
    parameter int AW    = 11,
    parameter int DW    = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] in_data;
    logic          ram_stall;
    logic          ram_we;
    logic [AW-1:0] ram_addrw;
    logic [DW-1:0] ram_dinw;
    logic [AW-1:0] rd_addr1;
    logic [AW-1:0] rd_addr2;
    logic          fwd_hit1;
    logic [DW-1:0] fwd_data1;
    logic          fwd_hit2;
    logic [DW-1:0] fwd_data2;
    logic [CW-1:0] count;
    logic          empty;

    modport master (
        output in_valid, in_addr, in_data, ram_stall, rd_addr1, rd_addr2,
        input  in_ready, ram_we, ram_addrw, ram_dinw,
        input  fwd_hit1, fwd_data1, fwd_hit2, fwd_data2, count, empty
    );

    modport slave (
        input  in_valid, in_addr, in_data, ram_stall, rd_addr1, rd_addr2,
        output in_ready, ram_we, ram_addrw, ram_dinw,
        output fwd_hit1, fwd_data1, fwd_hit2, fwd_data2, count, empty
    );
endinterface

// File: rtl/ram_wr_queue.sv
// rtl/ram_wr_queue.sv - circular write queue in front of the 2R1W RAM with store-to-load forwarding
// Define WRQ_COALESCE_EN to merge pushes into a pending entry with the same address.
module ram_wr_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 11,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    ram_wr_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0]    r_addr [DEPTH];
    logic [DW-1:0]    r_data [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_alloc;
    logic          w_coal_hit;
    logic [PW-1:0] w_coal_idx;
    logic          w_hit1;
    logic          w_hit2;
    logic [PW-1:0] w_idx1;
    logic [PW-1:0] w_idx2;

    // Walks oldest to youngest so the last match found is the youngest one.
    function automatic logic [PW:0] search(input logic [AW-1:0] a,
                                           input logic           excl_en,
                                           input logic [PW-1:0]  excl_idx);
        logic [PW:0]   res;
        logic [PW-1:0] idx;
        res = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            idx = r_wr_ptr - PW'(1) - PW'(i);
            if (r_valid[idx] && r_addr[idx] == a && !(excl_en && idx == excl_idx)) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_pop   = !w_empty && !bus.ram_stall;

    assign {w_hit1, w_idx1} = search(bus.rd_addr1, 1'b0, r_rd_ptr);
    assign {w_hit2, w_idx2} = search(bus.rd_addr2, 1'b0, r_rd_ptr);

`ifdef WRQ_COALESCE_EN
    // The head leaving this cycle cannot absorb new data, so it is excluded.
    assign {w_coal_hit, w_coal_idx} = search(bus.in_addr, w_pop, r_rd_ptr);
`else
    assign w_coal_hit = 1'b0;
    assign w_coal_idx = '0;
`endif

    assign bus.in_ready = !w_full || w_coal_hit;
    assign w_push       = bus.in_valid && bus.in_ready;
    assign w_alloc      = w_push && !w_coal_hit;

    assign bus.ram_we    = w_pop;
    assign bus.ram_addrw = r_addr[r_rd_ptr];
    assign bus.ram_dinw  = r_data[r_rd_ptr];
    assign bus.fwd_hit1  = w_hit1;
    assign bus.fwd_data1 = w_hit1 ? r_data[w_idx1] : '0;
    assign bus.fwd_hit2  = w_hit2;
    assign bus.fwd_data2 = w_hit2 ? r_data[w_idx2] : '0;
    assign bus.count     = r_count;
    assign bus.empty     = w_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_pop) begin
                r_valid[r_rd_ptr] <= 1'b0;
                r_rd_ptr          <= r_rd_ptr + PW'(1);
            end
            if (w_alloc) begin
                r_valid[r_wr_ptr] <= 1'b1;
                r_wr_ptr          <= r_wr_ptr + PW'(1);
            end
            if (w_alloc && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_alloc && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Payload storage carries no reset; the valid bits alone define occupancy.
    always_ff @(posedge clk) begin
        if (w_alloc) begin
            r_addr[r_wr_ptr] <= bus.in_addr;
            r_data[r_wr_ptr] <= bus.in_data;
        end else if (w_push && w_coal_hit) begin
            r_data[w_coal_idx] <= bus.in_data;
        end
    end
endmodule

// File: tb/tb_ram_wr_queue.sv
// tb/tb_ram_wr_queue.sv - scoreboard bench for ram_wr_queue
module tb_ram_wr_queue;
    localparam int DEPTH = 4;
    localparam int AW    = 11;
    localparam int DW    = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_vec = 0;
    int n_err = 0;

    logic [AW+DW-1:0] sb[$];

    ram_wr_queue_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

    ram_wr_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sb_add(input logic [AW-1:0] a, input logic [DW-1:0] d);
`ifdef WRQ_COALESCE_EN
        bit merged;
        merged = 1'b0;
        for (int i = sb.size() - 1; i >= 0 && !merged; i--) begin
            if (sb[i][AW+DW-1:DW] == a && !(i == 0 && !bus.ram_stall)) begin
                sb[i][DW-1:0] = d;
                merged = 1'b1;
            end
        end
        if (!merged) sb.push_back({a, d});
`else
        sb.push_back({a, d});
`endif
    endtask

    task automatic do_push(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int budget;
        bus.in_valid = 1'b1;
        bus.in_addr  = a;
        bus.in_data  = d;
        #1;
        budget = 0;
        while (!bus.in_ready && budget < 50) begin
            @(posedge clk); #1;
            budget++;
        end
        if (!bus.in_ready) begin
            chk("push_accept_timeout", 64'(bus.in_ready), 64'd1);
        end else begin
            sb_add(a, d);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        #1;
    endtask

    task automatic wait_empty();
        int budget;
        budget = 0;
        while (!bus.empty && budget < 40) begin
            @(posedge clk); #1;
            budget++;
        end
        chk("drain_empty", 64'(bus.empty), 64'd1);
    endtask

    // Monitor: every RAM write must match the oldest expected write.
    initial begin
        logic [AW+DW-1:0] e;
        forever begin
            @(negedge clk);
            if (!rst && bus.ram_we) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ram_write", 64'(bus.ram_addrw), 64'h7FF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("ram_addrw", 64'(bus.ram_addrw), 64'(e[AW+DW-1:DW]));
                    chk("ram_dinw",  64'(bus.ram_dinw),  64'(e[DW-1:0]));
                end
            end
        end
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_addr   = '0;
        bus.in_data   = '0;
        bus.ram_stall = 1'b0;
        bus.rd_addr1  = '0;
        bus.rd_addr2  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_empty",     64'(bus.empty),     64'd1);
        chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
        chk("rst_ram_we",    64'(bus.ram_we),    64'd0);
        chk("rst_fwd_hit1",  64'(bus.fwd_hit1),  64'd0);
        chk("rst_fwd_data1", 64'(bus.fwd_data1), 64'd0);
        chk("rst_fwd_hit2",  64'(bus.fwd_hit2),  64'd0);
        chk("rst_count",     64'(bus.count),     64'd0);
        rst = 1'b0;
        #1;

        // Single write appears on the RAM port one cycle after acceptance.
        do_push(11'h010, 32'hDEAD_BEEF);
        chk("t1_ram_we",  64'(bus.ram_we),    64'd1);
        chk("t1_addrw",   64'(bus.ram_addrw), 64'h010);
        chk("t1_dinw",    64'(bus.ram_dinw),  64'hDEAD_BEEF);
        @(posedge clk); #2;
        chk("t1_empty",   64'(bus.empty),     64'd1);

        // Fill under stall, then drain four back-to-back writes.
        bus.ram_stall = 1'b1;
        for (int i = 1; i <= 4; i++) do_push(AW'(i), DW'(i));
        chk("t2_count",    64'(bus.count),    64'd4);
        chk("t2_in_ready", 64'(bus.in_ready), 64'd0);
        chk("t2_ram_we",   64'(bus.ram_we),   64'd0);
        bus.ram_stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t2_drain_we", 64'(bus.ram_we), 64'd1);
            @(posedge clk); #1;
        end
        chk("t2_empty", 64'(bus.empty), 64'd1);

        // Full queue with a held request: pop first, acceptance one cycle later.
        bus.ram_stall = 1'b1;
        for (int i = 1; i <= 4; i++) do_push(AW'(11'h020 + i), DW'(32'h120 + i));
        bus.in_valid = 1'b1;
        bus.in_addr  = 11'h025;
        bus.in_data  = 32'h125;
        #1;
        chk("t3_full_ready", 64'(bus.in_ready), 64'd0);
        chk("t3_full_count", 64'(bus.count),    64'd4);
        bus.ram_stall = 1'b0;
        #1;
        chk("t3_pop_we",     64'(bus.ram_we),   64'd1);
        chk("t3_pop_ready",  64'(bus.in_ready), 64'd0);
        @(posedge clk); #1;
        chk("t3_count_a",    64'(bus.count),    64'd3);
        chk("t3_ready_a",    64'(bus.in_ready), 64'd1);
        sb_add(11'h025, 32'h125);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        #1;
        chk("t3_count_b",    64'(bus.count),    64'd3);
        wait_empty();
        chk("t3_sb_drained", 64'(sb.size()),    64'd0);

        // Forwarding returns the youngest pending match.
        bus.ram_stall = 1'b1;
        do_push(11'h005, 32'h11);
        do_push(11'h005, 32'h22);
        bus.rd_addr1 = 11'h005;
        bus.rd_addr2 = 11'h006;
        #1;
        chk("t4_hit1",  64'(bus.fwd_hit1),  64'd1);
        chk("t4_data1", 64'(bus.fwd_data1), 64'h22);
        chk("t4_hit2",  64'(bus.fwd_hit2),  64'd0);
        chk("t4_data2", 64'(bus.fwd_data2), 64'd0);
`ifdef WRQ_COALESCE_EN
        chk("t4_count", 64'(bus.count), 64'd1);
`else
        chk("t4_count", 64'(bus.count), 64'd2);
`endif
        bus.ram_stall = 1'b0;
        #1;
        chk("t4_hit1_popping",  64'(bus.fwd_hit1),  64'd1);
        chk("t4_data1_popping", 64'(bus.fwd_data1), 64'h22);
        wait_empty();
        #1;
        chk("t4_hit1_after", 64'(bus.fwd_hit1), 64'd0);

        // Asynchronous reset discards pending writes.
        bus.ram_stall = 1'b1;
        do_push(11'h031, 32'h31);
        do_push(11'h032, 32'h32);
        do_push(11'h033, 32'h33);
        bus.rd_addr1 = 11'h032;
        bus.rd_addr2 = 11'h033;
        #1;
        chk("t5_pre_hit1", 64'(bus.fwd_hit1), 64'd1);
        #1;
        rst = 1'b1;
        bus.ram_stall = 1'b0;
        #1;
        chk("t5_count",     64'(bus.count),     64'd0);
        chk("t5_empty",     64'(bus.empty),     64'd1);
        chk("t5_ram_we",    64'(bus.ram_we),    64'd0);
        chk("t5_fwd_hit1",  64'(bus.fwd_hit1),  64'd0);
        chk("t5_fwd_data1", 64'(bus.fwd_data1), 64'd0);
        chk("t5_fwd_hit2",  64'(bus.fwd_hit2),  64'd0);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("t5_still_empty", 64'(bus.empty), 64'd1);

`ifdef WRQ_COALESCE_EN
        // Same-address pushes merge into one entry carrying the last data.
        bus.ram_stall = 1'b1;
        do_push(11'h007, 32'hAA);
        do_push(11'h007, 32'hBB);
        chk("t6_count", 64'(bus.count), 64'd1);
        bus.ram_stall = 1'b0;
        wait_empty();
`endif

        // Free-running traffic across several pointer wraps.
        for (int i = 0; i < 10; i++) do_push(AW'(11'h100 + i), DW'(32'hA000 + i));
        wait_empty();
        repeat (2) @(posedge clk);
        #1;
        chk("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
